// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - bank of independent down-counting timer channels
// Each channel is IDLE/RUN/HOLD; commands win over the shared tick on their own channel.
module multi_timer #(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [WIDTH-1:0]    cmd_value,
  input  logic                cmd_reload,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [WIDTH-1:0]    rd_count,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] expire
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_e;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STOP   = 2'b11;

  state_e             state_q  [CHANNELS];
  state_e             state_d  [CHANNELS];
  logic [WIDTH-1:0]   count_q  [CHANNELS];
  logic [WIDTH-1:0]   count_d  [CHANNELS];
  logic [WIDTH-1:0]   reload_q [CHANNELS];
  logic [WIDTH-1:0]   reload_d [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] expire_q, expire_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      mode_d[i]   = mode_q[i];
      expire_d[i] = 1'b0;
      if (cmd_valid && (cmd_ch == CH_W'(i))) begin
        case (cmd_op)
          OP_START: begin
            if (cmd_value != '0) begin
              count_d[i]  = cmd_value;
              reload_d[i] = cmd_value;
              mode_d[i]   = cmd_reload;
              state_d[i]  = ST_RUN;
            end else begin
              // A zero-length start expires immediately without ever running.
              count_d[i]  = '0;
              state_d[i]  = ST_IDLE;
              expire_d[i] = 1'b1;
            end
          end
          OP_PAUSE:  if (state_q[i] == ST_RUN)  state_d[i] = ST_HOLD;
          OP_RESUME: if (state_q[i] == ST_HOLD) state_d[i] = ST_RUN;
          OP_STOP: begin
            state_d[i] = ST_IDLE;
            count_d[i] = '0;
          end
          default: ;
        endcase
      end else if (tick && (state_q[i] == ST_RUN)) begin
        if (count_q[i] <= WIDTH'(1)) begin
          expire_d[i] = 1'b1;
          if (mode_q[i]) begin
            count_d[i] = reload_q[i];
          end else begin
            count_d[i] = '0;
            state_d[i] = ST_IDLE;
          end
        end else begin
          count_d[i] = count_q[i] - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= ST_IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
      mode_q   <= '0;
      expire_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
      end
      mode_q   <= mode_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    rd_count = '0;
    busy     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = (state_q[i] != ST_IDLE);
      if (rd_ch == CH_W'(i)) rd_count = count_q[i];
    end
  end

  assign expire = expire_q;

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter WIDTH, 9, bit width of every counter, reload value and load value.
REQ-002 SHALL have parameter CHANNELS, 4, number of independent timer channels (2..16).
REQ-003 SHALL have parameter CH_W, 2, width of channel-select ports; CHANNELS <= 2**CH_W.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tick  input  1  global count enable (one pulse per 1/32 s beat), sampled on clk.
REQ-007 SHALL have port cmd_valid  input  1  command strobe, one command per asserted cycle.
REQ-008 SHALL have port cmd_op  input  2  00 START, 01 PAUSE, 10 RESUME, 11 STOP.
REQ-009 SHALL have port cmd_ch  input  CH_W  target channel of command.
REQ-010 SHALL have port cmd_value  input  WIDTH  load value for START.
REQ-011 SHALL have port cmd_reload  input  1  START mode: 0 one-shot, 1 auto-reload.
REQ-012 SHALL have port rd_ch  input  CH_W  readback channel select.
REQ-013 SHALL have port rd_count  output  WIDTH  combinational current count of channel rd_ch; 0 when rd_ch >= CHANNELS.
REQ-014 SHALL have port busy  output  CHANNELS  bit i high while channel i is RUN or HOLD.
REQ-015 SHALL have port expire  output  CHANNELS  bit i registered one-cycle pulse on channel i expiry.

Function
REQ-016 Each channel SHALL hold: count (WIDTH), reload (WIDTH), mode (1), state in {IDLE, RUN, HOLD}.
REQ-017 START with cmd_value > 0 SHALL, at the next edge, set count = reload = cmd_value, mode = cmd_reload, state = RUN, from any state.
REQ-018 START with cmd_value = 0 SHALL leave state IDLE, set count = 0, and assert expire[ch] in the following cycle.
REQ-019 In RUN, a cycle with tick = 1 and no command to that channel SHALL decrement count by 1.
REQ-020 In RUN, tick with count = 1 SHALL be expiry: expire[i] = 1 in the next cycle only; one-shot -> count = 0, state IDLE; auto-reload -> count = reload, state stays RUN.
REQ-021 Ticks SHALL be ignored in IDLE and HOLD; count holds.
REQ-022 PAUSE SHALL move RUN -> HOLD; no effect in IDLE or HOLD.
REQ-023 RESUME SHALL move HOLD -> RUN; no effect in IDLE or RUN.
REQ-024 STOP SHALL force IDLE, count = 0 from any state, with no expire pulse.
REQ-025 Command and tick in the same cycle on the same channel: command SHALL take effect, tick ignored for that channel; all other channels still process the tick.
REQ-026 Commands with cmd_ch >= CHANNELS SHALL be ignored.
REQ-027 Multiple channels expiring on the same tick SHALL each pulse their expire bit in the same cycle.
REQ-028 Counters SHALL never wrap below 0; no arithmetic overflow is possible since only decrement and load occur.
REQ-029 busy SHALL be a direct decode of registered state (no extra latency).

Reset
REQ-030 While reset is high, all channels SHALL be IDLE with count = 0, reload = 0, mode = 0; expire = 0, busy = 0, rd_count = 0.
REQ-031 Reset asserted mid-count SHALL abort immediately with no expire pulse; after release, channels stay IDLE until START.

Verification
REQ-032 START ch0 value 3 one-shot, tick every cycle -> count 3,2,1, expire[0] one cycle after third tick, busy[0] low same cycle, count 0.
REQ-033 START ch1 value 2 auto-reload, 6 ticks -> expire[1] pulses after ticks 2, 4, 6; busy[1] stays high; rd_count (rd_ch=1) 2,1,2,1,2,1,2.
REQ-034 ch2 RUN count 5, PAUSE, 3 ticks, RESUME, 2 ticks -> count 5 during HOLD, 3 at end, no expire.
REQ-035 ch0 count 1 with tick and STOP same cycle -> count 0, IDLE, no expire; ch3 count 1 same tick -> expire[3] pulses.
REQ-036 START value 0 on ch1 -> busy[1] stays 0, expire[1] pulses once next cycle; START with cmd_ch = 5 (CHANNELS 4, CH_W 3) -> no state change.
REQ-037 Assert reset with ch0 count 4 RUN -> immediately count 0, busy 0, expire 0; ticks after release leave all counts 0.
